// File: rtl/dsm_dac_sine_top.sv
// dsm_dac_sine_top: strobed 50-point sine LUT feeding a first-order delta-sigma DAC bitstream.
module clk_div #(
  parameter int DIV = 2
) (
  input  logic clk,
  input  logic rst,
  output logic clk_en
);
  localparam int CW = DIV > 1 ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);
  logic [CW-1:0] cnt;
  always_ff @(posedge clk)
    if (rst) begin
      cnt <= '0;
      clk_en <= 1'b0;
    end else begin
      clk_en <= cnt == LAST;
      cnt <= cnt == LAST ? '0 : cnt + 1'b1;
    end
endmodule

module sin_gen #(
  parameter int N_PTS = 50,
  parameter int DATA_WIDTH = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         clk_en,
  output logic signed [DATA_WIDTH-1:0] sin_out
);
  localparam int IW = N_PTS > 1 ? $clog2(N_PTS) : 1;
  localparam logic [IW-1:0] LAST = IW'(N_PTS - 1);
  // round(32767*sin(2*pi*k/50)); the table is tabulated for 50 points per period
  localparam logic signed [15:0] LUT [50] = '{
    16'sd0, 16'sd4107, 16'sd8149, 16'sd12062, 16'sd15786, 16'sd19260, 16'sd22431,
    16'sd25247, 16'sd27666, 16'sd29648, 16'sd31163, 16'sd32187, 16'sd32702,
    16'sd32702, 16'sd32187, 16'sd31163, 16'sd29648, 16'sd27666, 16'sd25247,
    16'sd22431, 16'sd19260, 16'sd15786, 16'sd12062, 16'sd8149, 16'sd4107,
    16'sd0, -16'sd4107, -16'sd8149, -16'sd12062, -16'sd15786, -16'sd19260, -16'sd22431,
    -16'sd25247, -16'sd27666, -16'sd29648, -16'sd31163, -16'sd32187, -16'sd32702,
    -16'sd32702, -16'sd32187, -16'sd31163, -16'sd29648, -16'sd27666, -16'sd25247,
    -16'sd22431, -16'sd19260, -16'sd15786, -16'sd12062, -16'sd8149, -16'sd4107
  };
  logic [IW-1:0] idx;
  always_ff @(posedge clk)
    if (rst) begin
      idx <= '0;
      sin_out <= '0;
    end else if (clk_en) begin
      sin_out <= LUT[idx];
      idx <= idx == LAST ? '0 : idx + 1'b1;
    end
endmodule

module first_order_dsm_dac #(
  parameter int DATA_WIDTH = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic signed [DATA_WIDTH-1:0] din,
  input  logic                         dsm_en,
  output logic                         dsm_out
);
  logic [DATA_WIDTH-1:0] acc;
  logic [DATA_WIDTH:0] s;
  // flipping the sign bit turns two's complement into offset binary
  always_comb s = {1'b0, acc} + {1'b0, din ^ {1'b1, {(DATA_WIDTH-1){1'b0}}}};
  always_ff @(posedge clk)
    if (rst) begin
      acc <= '0;
      dsm_out <= 1'b0;
    end else if (dsm_en) begin
      {dsm_out, acc} <= s;
    end
endmodule

module dsm_dac_sine_top #(
  parameter int DIV = 2,
  parameter int DATA_WIDTH = 16,
  parameter int N_PTS = 50
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         dsm_en,
  output logic                         clk_en,
  output logic signed [DATA_WIDTH-1:0] sin_out,
  output logic                         dsm_out
);
  clk_div #(.DIV(DIV)) u_div (
    .clk(clk),
    .rst(rst),
    .clk_en(clk_en)
  );
  sin_gen #(.N_PTS(N_PTS), .DATA_WIDTH(DATA_WIDTH)) u_sin (
    .clk(clk),
    .rst(rst),
    .clk_en(clk_en),
    .sin_out(sin_out)
  );
  first_order_dsm_dac #(.DATA_WIDTH(DATA_WIDTH)) u_dsm (
    .clk(clk),
    .rst(rst),
    .din(sin_out),
    .dsm_en(dsm_en),
    .dsm_out(dsm_out)
  );
endmodule

// File: tb/tb_dsm_dac_sine_top.sv
// tb_dsm_dac_sine_top: scoreboard bench for the sine-driven delta-sigma DAC.
module tb_dsm_dac_sine_top;
  localparam int DIV = 2;
  localparam int N = 50;
  typedef struct {
    logic en;
    int sin;
    logic dsm;
  } exp_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic dsm_en = 1'b0;
  logic clk_en;
  logic signed [15:0] sin_out;
  logic dsm_out;
  logic t_rst = 1'b1;
  logic t_en = 1'b0;
  logic signed [15:0] t_sin = '0;
  logic t_dsm;
  int n_cmp = 0;
  int n_bad = 0;
  int lut [N];
  int m_cnt, m_idx, m_sin, m_acc;
  logic m_en, m_dsm;
  int sc = 0;
  logic prev_en = 1'b0;
  exp_t sb [$];
  int sp_n [7] = '{1, 13, 14, 26, 38, 51, 52};
  int sp_v [7] = '{0, 32702, 32702, 0, -32702, 0, 4107};

  dsm_dac_sine_top #(.DIV(DIV), .DATA_WIDTH(16), .N_PTS(N)) dut (
    .clk(clk),
    .rst(rst),
    .dsm_en(dsm_en),
    .clk_en(clk_en),
    .sin_out(sin_out),
    .dsm_out(dsm_out)
  );
  first_order_dsm_dac #(.DATA_WIDTH(16)) u_mod (
    .clk(clk),
    .rst(t_rst),
    .din(t_sin),
    .dsm_en(t_en),
    .dsm_out(t_dsm)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic model_step(input logic r, input logic e);
    int s;
    if (r) begin
      m_cnt = 0; m_en = 0; m_idx = 0; m_sin = 0; m_acc = 0; m_dsm = 0;
    end else begin
      if (e) begin
        s = m_acc + m_sin + 32768;
        m_dsm = s >= 65536;
        m_acc = s % 65536;
      end
      if (m_en) begin
        m_sin = lut[m_idx];
        m_idx = (m_idx + 1) % N;
      end
      m_en = m_cnt == DIV - 1;
      m_cnt = (m_cnt + 1) % DIV;
    end
  endtask

  task automatic cyc(input logic r, input logic e);
    exp_t x;
    rst = r;
    dsm_en = e;
    model_step(r, e);
    sb.push_back('{m_en, m_sin, m_dsm});
    @(posedge clk);
    #1;
    x = sb.pop_front();
    check("clk_en", int'(clk_en), int'(x.en));
    check("sin_out", int'(sin_out), x.sin);
    check("dsm_out", int'(dsm_out), int'(x.dsm));
    check("acc", int'(dut.u_dsm.acc), m_acc);
    if (r) sc = 0;
    else if (prev_en) begin
      sc++;
      foreach (sp_n[i]) if (sp_n[i] == sc) check($sformatf("strobe%0d_sin", sc), int'(sin_out), sp_v[i]);
    end
    prev_en = clk_en;
  endtask

  initial begin
    int hi, k;
    for (int i = 0; i < N; i++) lut[i] = int'(32767.0 * $sin(2.0 * 3.141592653589793 * i / N));
    cyc(1, 0);
    cyc(1, 0);
    hi = 0;
    for (int i = 0; i < 40; i++) begin
      cyc(0, 1);
      hi += int'(clk_en);
    end
    check("strobes_in_40", hi, 20);
    for (int i = 0; i < 200 && sc < 52; i++) cyc(0, 1);
    check("reach_strobe52", sc, 52);
    repeat (10) cyc(0, 0);
    repeat (30) cyc(0, 1);
    cyc(1, 1);
    for (int i = 0; i < 100 && sc < 20; i++) cyc(0, 1);
    check("reach_strobe20", sc, 20);
    cyc(1, 1);
    check("mr_clk_en", int'(clk_en), 0);
    check("mr_sin", int'(sin_out), 0);
    check("mr_dsm", int'(dsm_out), 0);
    k = 0;
    do begin
      cyc(0, 1);
      k++;
    end while (!clk_en && k < 10);
    check("mr_first_strobe_edge", k, DIV);
    repeat (4) cyc(0, 1);
    check("mr_strobe_count", sc, 2);
    t_rst = 1'b1; t_en = 1'b0; t_sin = 16'sd0;
    @(posedge clk); #1;
    t_rst = 1'b0; t_en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      check("mid_stream", int'(t_dsm), i % 2);
    end
    t_rst = 1'b1; t_sin = -16'sd32768;
    @(posedge clk); #1;
    t_rst = 1'b0;
    hi = 0;
    repeat (1000) begin
      @(posedge clk); #1;
      hi += int'(t_dsm);
    end
    check("min_ones", hi, 0);
    t_rst = 1'b1; t_sin = 16'sd32767;
    @(posedge clk); #1;
    t_rst = 1'b0;
    @(posedge clk); #1;
    check("max_first", int'(t_dsm), 0);
    hi = 0;
    repeat (1000) begin
      @(posedge clk); #1;
      hi += int'(t_dsm);
    end
    check("max_ones", hi, 1000);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
